// File: rtl/stream_aligner.sv
// ---------------------------------------------------------------------------
// stream_aligner
//   Realigns a packetized word stream by a per-packet bit offset. Output word
//   k of a packet is bits [ofs + k*DATA +: DATA] of the little-endian
//   concatenation of that packet's input words. A packet of N input words
//   always yields N output words; the last one carries out_last.
//
//   Build option: STREAM_ALIGNER_ZPAD_EN
//     defined   : final word = H >> ofs (upper ofs bits zero)
//     undefined : final word = H rotated right by ofs
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   cfg_ofs    bit offset, sampled when the first word of a packet is accepted
//   in_valid   input word valid
//   in_ready   input word accepted when in_valid && in_ready
//   in_data    input word
//   in_last    final input word of a packet
//   out_valid  output word valid
//   out_ready  consumer ready
//   out_data   aligned output word
//   out_last   final output word of a packet
// ---------------------------------------------------------------------------

// Barrel shifter by index. Rotation is taken from a doubled copy of the
// input; the result is truncated to OUT_W bits.
module sa_shifter #(
  parameter int WIDTH    = 16,
  parameter int SHAMT    = 3,
  parameter int OUT_W    = WIDTH,
  parameter bit ROTATE   = 1'b0,
  parameter bit TO_RIGHT = 1'b1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHAMT-1:0] i_shamt,
  output logic [OUT_W-1:0] o_data
);
  generate
    if (ROTATE && TO_RIGHT) begin : g_ror
      assign o_data = OUT_W'({i_data, i_data} >> i_shamt);
    end else if (ROTATE) begin : g_rol
      assign o_data = OUT_W'(({i_data, i_data} << i_shamt) >> WIDTH);
    end else if (TO_RIGHT) begin : g_shr
      assign o_data = OUT_W'(i_data >> i_shamt);
    end else begin : g_shl
      assign o_data = OUT_W'(i_data << i_shamt);
    end
  endgenerate
endmodule

module stream_aligner #(
  parameter int DATA = 32,
  parameter int OFS  = $clog2(DATA)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OFS-1:0]  cfg_ofs,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic            out_last
);

  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  logic [DATA-1:0] r_hold;
  logic [OFS-1:0]  r_ofs;
  logic            r_out_valid;
  logic [DATA-1:0] r_out_data;
  logic            r_out_last;

  logic            w_slot_free;
  logic            w_accept;
  logic [DATA-1:0] w_mid_word;
  logic [DATA-1:0] w_flush_word;

  assign w_slot_free = !r_out_valid || out_ready;

  // IDLE only captures into H, so it never depends on the output slot.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD:  in_ready = w_slot_free;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // Window over the new word and the held word: {in_data, H} >> ofs.
  sa_shifter #(
    .WIDTH    (2*DATA),
    .SHAMT    (OFS),
    .OUT_W    (DATA),
    .ROTATE   (DISABLE),
    .TO_RIGHT (ENABLE)
  ) u_shift_mid (
    .i_data   ({in_data, r_hold}),
    .i_shamt  (r_ofs),
    .o_data   (w_mid_word)
  );

`ifdef STREAM_ALIGNER_ZPAD_EN
  assign w_flush_word = r_hold >> r_ofs;
`else
  sa_shifter #(
    .WIDTH    (DATA),
    .SHAMT    (OFS),
    .OUT_W    (DATA),
    .ROTATE   (ENABLE),
    .TO_RIGHT (ENABLE)
  ) u_shift_flush (
    .i_data   (r_hold),
    .i_shamt  (r_ofs),
    .o_data   (w_flush_word)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_ofs       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      // Drain first; a reload below in the same cycle overrides it.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hold  <= in_data;
            r_ofs   <= cfg_ofs;
            r_state <= in_last ? S_FLUSH : S_HOLD;
          end
        end

        S_HOLD: begin
          if (w_accept) begin
            r_out_data  <= w_mid_word;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_hold      <= in_data;
            r_state     <= in_last ? S_FLUSH : S_HOLD;
          end
        end

        S_FLUSH: begin
          if (w_slot_free) begin
            r_out_data  <= w_flush_word;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_aligner.sv
module tb_stream_aligner;

  localparam int DATA = 8;
  localparam int OFS  = 3;
`ifdef STREAM_ALIGNER_ZPAD_EN
  localparam bit ZPAD = 1'b1;
`else
  localparam bit ZPAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [OFS-1:0]  cfg_ofs = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DATA-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DATA-1:0] out_data;
  logic            out_last;

  int n_total = 0;
  int n_bad   = 0;
  bit rand_rdy = 1'b0;

  stream_aligner #(.DATA(DATA)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_ofs   (cfg_ofs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference model: bit-level view of the packet as one long little-endian
  // vector; bits beyond its end are zero (ZPAD) or wrap within the last word.
  logic [7:0] pkt[$];
  int         pkt_ofs;
  logic [8:0] expq[$];
  logic [8:0] obsq[$];
  logic [8:0] o_w, e_w;

  function automatic void build_exp();
    int n;
    n = pkt.size();
    for (int k = 0; k < n; k++) begin
      logic [7:0] w;
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = pkt_ofs + k*8 + j;
        if (idx < n*8) w[j] = pkt[idx/8][idx%8];
        else if (ZPAD) w[j] = 1'b0;
        else           w[j] = pkt[(idx-8)/8][(idx-8)%8];
      end
      expq.push_back({(k == n-1), w});
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pkt.delete();
      expq.delete();
      obsq.delete();
    end else begin
      if (out_valid && out_ready) obsq.push_back({out_last, out_data});
      if (in_valid && in_ready) begin
        if (pkt.size() == 0) pkt_ofs = int'(cfg_ofs);
        pkt.push_back(in_data);
        if (in_last) begin
          build_exp();
          pkt.delete();
        end
      end
      while (obsq.size() > 0 && expq.size() > 0) begin
        o_w = obsq.pop_front();
        e_w = expq.pop_front();
        chk("out_data", 32'(o_w[7:0]), 32'(e_w[7:0]));
        chk("out_last", 32'(o_w[8]), 32'(e_w[8]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_word(input logic [7:0] d, input bit last, input logic [OFS-1:0] ofs);
    int  waited;
    bit  done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    cfg_ofs  = ofs;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waited++;
        if (waited > 200) begin
          chk("in_timeout", 0, 1);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle_cycles(3);
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_last",  32'(out_last), 0);
    chk("rst_ready", 32'(in_ready), 1);

    // offset 4, three words, free-running consumer; cfg_ofs moved mid-packet
    out_ready = 1'b1;
    drive_word(8'h21, 1'b0, 3'd4);
    drive_word(8'h43, 1'b0, 3'd3);
    drive_word(8'h65, 1'b1, 3'd1);
    chk("flush_bubble", 32'(in_ready), 0);
    chk("pre_flush_data", 32'(out_data), 32'h54);
    idle_cycles(1);
    chk("flush_valid", 32'(out_valid), 1);
    chk("flush_last",  32'(out_last), 1);
    chk("flush_data",  32'(out_data), ZPAD ? 32'h06 : 32'h56);
    chk("idle_ready",  32'(in_ready), 1);
    idle_cycles(2);

    // zero offset passthrough and a single-word packet
    drive_word(8'hA5, 1'b0, 3'd0);
    drive_word(8'h3C, 1'b1, 3'd0);
    drive_word(8'h7E, 1'b1, 3'd0);
    idle_cycles(1);
    chk("single_data", 32'(out_data), 32'h7E);
    chk("single_last", 32'(out_last), 1);
    idle_cycles(2);

    // backpressure after the first output word
    drive_word(8'h21, 1'b0, 3'd4);
    drive_word(8'h43, 1'b0, 3'd4);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h65;
    in_last   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data",  32'(out_data), 32'h32);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive_word(8'h65, 1'b1, 3'd4);
    idle_cycles(3);

    // back-to-back packets with different offsets
    drive_word(8'hFF, 1'b0, 3'd1);
    drive_word(8'h01, 1'b1, 3'd6);
    drive_word(8'h80, 1'b0, 3'd7);
    drive_word(8'h00, 1'b1, 3'd2);
    idle_cycles(1);
    chk("b2b_last_data", 32'(out_data), ZPAD ? 32'h00 : 32'h00);
    idle_cycles(2);

    // reset while a word is pending in HOLD
    out_ready = 1'b0;
    drive_word(8'h21, 1'b0, 3'd4);
    drive_word(8'h43, 1'b0, 3'd4);
    chk("pre_rst_valid", 32'(out_valid), 1);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data",  32'(out_data), 0);
    chk("mid_rst_last",  32'(out_last), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    drive_word(8'h81, 1'b0, 3'd2);
    drive_word(8'h7E, 1'b1, 3'd5);
    idle_cycles(3);

    // randomized packets with random consumer stalls
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        drive_word(8'($urandom), (i == n-1), 3'($urandom));
        idle_cycles($urandom_range(0, 1));
      end
      idle_cycles($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    idle_cycles(10);
    chk("leftover", 32'(obsq.size() + expq.size() + pkt.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
